// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write scheduler: command bytes,
// default phase timings and the scheduler state encoding.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;

    localparam int DEF_SETUP_CYC = 5;
    localparam int DEF_PULSE_CYC = 50;
    localparam int DEF_STD_WAIT  = 2000;
    localparam int DEF_LONG_WAIT = 90000;
    localparam int DEF_CNT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/lcd_write_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward
// (with wrap) from the pointer plus one.
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_idx,
    output logic               o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = 2'd0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_valid && i_req[i] && (i == ((int'(i_ptr) + k) % NUM_REQ))) begin
                    o_grant[i] = 1'b1;
                    o_idx      = 2'(i);
                    o_valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_write_sched.sv
// HD44780 post-init write scheduler: passes the init sequencer through until
// it reports done, then arbitrates requesters and sequences each bus write.
module lcd_write_sched
    import lcd_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int STD_WAIT  = DEF_STD_WAIT,
    parameter int LONG_WAIT = DEF_LONG_WAIT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_init_done,
    input  logic [7:0]           i_init_data,
    input  logic                 i_init_rs,
    input  logic                 i_init_rw,
    input  logic                 i_init_e,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_rs,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [1:0]           o_grant_id,
    output logic                 o_busy,
    output logic [7:0]           o_lcd_data,
    output logic                 o_lcd_rs,
    output logic                 o_lcd_rw,
    output logic                 o_lcd_e
);

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_STD   = CNT_W'(STD_WAIT - 1);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_WAIT - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_init_seen, r_first, r_rs;
    logic [7:0]         r_data;
    logic [1:0]         r_ptr, r_grant;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [1:0]         w_gnt_idx;
    logic               w_gnt_valid, w_start, w_long, w_sel_rs;
    logic [7:0]         w_sel_data;

    lcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    always_comb begin
        w_sel_data = 8'h00;
        w_sel_rs   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_data = i_req_data[8*i +: 8];
                w_sel_rs   = i_req_rs[i];
            end
        end
    end

    // Clear (0x01) and home (0x02/0x03) need the long busy-wait.
    assign w_long  = !r_rs && ((r_data == CMD_CLEAR) || (r_data == CMD_HOME) || (r_data == 8'h03));
    assign w_start = (r_state == ST_IDLE) && r_init_seen && w_gnt_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = C_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_SETUP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = w_long ? C_LONG : C_STD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_init_seen <= 1'b0;
            r_first     <= 1'b0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_ptr       <= 2'(NUM_REQ - 1);
            r_grant     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_seen <= r_init_seen | i_init_done;
            r_first     <= w_start;
            if (w_start) begin
                r_data  <= w_sel_data;
                r_rs    <= w_sel_rs;
                r_ptr   <= w_gnt_idx;
                r_grant <= w_gnt_idx;
            end
        end
    end

    assign o_ack      = (r_state == ST_SETUP && r_first) ? (NUM_REQ'(1) << r_grant) : '0;
    assign o_grant_id = r_grant;
    assign o_busy     = !r_init_seen || (r_state != ST_IDLE);
    assign o_lcd_data = r_init_seen ? ((r_state == ST_IDLE) ? 8'h00 : r_data) : i_init_data;
    assign o_lcd_rs   = r_init_seen ? ((r_state == ST_IDLE) ? 1'b0 : r_rs) : i_init_rs;
    assign o_lcd_rw   = r_init_seen ? 1'b0 : i_init_rw;
    assign o_lcd_e    = r_init_seen ? (r_state == ST_PULSE) : i_init_e;

endmodule

// File: tb/tb_lcd_write_sched.sv
// Scenario bench for lcd_write_sched with shortened phase timings.
module tb_lcd_write_sched;

    localparam int NR = 2;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int SW = 10;
    localparam int LW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic [7:0]    init_data = 8'h00;
    logic          init_rs = 1'b0, init_rw = 1'b0, init_e = 1'b0;
    logic [NR-1:0] req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_rs = '0;
    logic [NR-1:0] ack;
    logic [1:0]    grant_id;
    logic          busy;
    logic [7:0]    lcd_data;
    logic          lcd_rs, lcd_rw, lcd_e;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       rs;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    lcd_write_sched #(
        .NUM_REQ(NR), .SETUP_CYC(S), .PULSE_CYC(P),
        .STD_WAIT(SW), .LONG_WAIT(LW), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_init_done(init_done), .i_init_data(init_data),
        .i_init_rs(init_rs), .i_init_rw(init_rw), .i_init_e(init_e),
        .i_req(req), .i_req_data(req_data), .i_req_rs(req_rs),
        .o_ack(ack), .o_grant_id(grant_id), .o_busy(busy),
        .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_wait(logic [7:0] d, logic rs);
        return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : SW;
    endfunction

    task automatic test_reset();
        #3;
        n_checks++;
        if (ack !== 2'b00 || busy !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b busy=%b grant_id=%0d, want 00 1 0", ack, busy, grant_id);
        end
        n_checks++;
        if (lcd_data !== 8'h00 || lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lcd: data=%h e=%b rs=%b rw=%b, want 00 0 0 0", lcd_data, lcd_e, lcd_rs, lcd_rw);
        end
    endtask

    task automatic test_passthrough();
        int acks = 0, not_busy = 0;
        tick();
        rst_n = 1'b1;
        init_data = 8'h38; init_e = 1'b1; init_rs = 1'b0; init_rw = 1'b1;
        req[0] = 1'b1; req_data[7:0] = 8'h41; req_rs[0] = 1'b1;
        #1;
        n_checks++;
        if (lcd_data !== 8'h38 || lcd_e !== 1'b1 || lcd_rw !== 1'b1 || lcd_rs !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough_bus: data=%h e=%b rw=%b rs=%b, want 38 1 1 0", lcd_data, lcd_e, lcd_rw, lcd_rs);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack !== 2'b00) acks++;
            if (busy !== 1'b1) not_busy++;
        end
        n_checks++;
        if (acks != 0 || not_busy != 0) begin
            n_fail++;
            $display("FAIL passthrough_hold: ack_cycles=%0d not_busy_cycles=%0d, want 0 0", acks, not_busy);
        end
        init_e = 1'b0; init_rw = 1'b0; init_data = 8'h00;
    endtask

    // init_done lands on the same edge as a pending request.
    task automatic test_init_same_edge();
        init_done = 1'b1;
        tick();
        n_checks++;
        if (ack !== 2'b00 || busy !== 1'b0 || lcd_rw !== 1'b0 || lcd_e !== 1'b0) begin
            n_fail++;
            $display("FAIL init_same_edge: ack=%b busy=%b rw=%b e=%b, want 00 0 0 0", ack, busy, lcd_rw, lcd_e);
        end
    endtask

    task automatic test_single_write(input int id, input logic [7:0] d, input logic rs);
        exp_t e;
        int n, total, bad_e, bad_d, bad_b, bad_a;
        sb.push_back('{id: id, data: d, rs: rs});
        req_data[8*id +: 8] = d; req_rs[id] = rs; req[id] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ack === 2'b00 && n < 20);
        n_checks++;
        if (ack === 2'b00) begin
            n_fail++;
            $display("FAIL write_ack_timeout: id=%0d no ack after %0d cycles", id, n);
            req[id] = 1'b0;
            void'(sb.pop_front());
            return;
        end
        req[id] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (ack !== NR'(1 << e.id) || grant_id !== 2'(e.id)) begin
            n_fail++;
            $display("FAIL write_ack_id: ack=%b grant_id=%0d, want id %0d", ack, grant_id, e.id);
        end
        total = 2*S + P + exp_wait(e.data, e.rs);
        bad_e = 0; bad_d = 0; bad_b = 0; bad_a = 0;
        for (int k = 0; k < total; k++) begin
            if (lcd_e !== ((k >= S && k < S + P) ? 1'b1 : 1'b0)) bad_e++;
            if (lcd_data !== e.data || lcd_rs !== e.rs || lcd_rw !== 1'b0) bad_d++;
            if (busy !== 1'b1) bad_b++;
            if (k > 0 && ack !== 2'b00) bad_a++;
            tick();
        end
        n_checks++;
        if (bad_e != 0 || bad_d != 0) begin
            n_fail++;
            $display("FAIL write_phases: id=%0d e_err=%0d data_err=%0d cycles, want 0 0", id, bad_e, bad_d);
        end
        n_checks++;
        if (bad_b != 0 || bad_a != 0) begin
            n_fail++;
            $display("FAIL write_busy_ack: id=%0d busy_err=%0d extra_ack=%0d, want 0 0", id, bad_b, bad_a);
        end
        n_checks++;
        if (busy !== 1'b0 || lcd_data !== 8'h00 || lcd_e !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle_at_%0d: busy=%b data=%h e=%b, want 0 00 0", total, busy, lcd_data, lcd_e);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int n, last_ack, idle_seen;
        req_data = {8'h31, 8'h30}; req_rs = 2'b11; req = 2'b11;
        for (int i = 0; i < 4; i++) sb.push_back('{id: i % 2, data: 8'h30 + 8'(i % 2), rs: 1'b1});
        last_ack = -100; idle_seen = 1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                tick(); n++;
                if (busy === 1'b0) idle_seen = 1;
            end while (ack === 2'b00 && n < 60);
            e = sb.pop_front();
            n_checks++;
            if (ack !== NR'(1 << e.id) || grant_id !== 2'(e.id) || lcd_data !== e.data) begin
                n_fail++;
                $display("FAIL contention_%0d: ack=%b grant_id=%0d data=%h, want id %0d data %h", t, ack, grant_id, lcd_data, e.id, e.data);
            end
            n_checks++;
            if (idle_seen == 0 || (t > 0 && (n < 2*S + P + SW))) begin
                n_fail++;
                $display("FAIL contention_gap_%0d: idle_seen=%0d gap=%0d, want 1 and >=%0d", t, idle_seen, n, 2*S + P + SW);
            end
            idle_seen = 0;
            last_ack = n;
        end
        req = 2'b00;
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b0 && n < 60);
    endtask

    task automatic test_withdraw_stable();
        int n, bad_d, acks1;
        req_data[7:0] = 8'h55; req_rs[0] = 1'b1; req[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ack === 2'b00 && n < 20);
        req[0] = 1'b0;
        req_data[7:0] = 8'hAA; req_rs[0] = 1'b0;
        bad_d = 0; acks1 = 0;
        for (int k = 0; k < 2*S + P + SW; k++) begin
            if (k == 3) req[1] = 1'b1;
            if (k == 4) req[1] = 1'b0;
            if (lcd_data !== 8'h55 || lcd_rs !== 1'b1) bad_d++;
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            if (ack[1] === 1'b1) acks1++;
            tick();
        end
        n_checks++;
        if (bad_d != 0) begin
            n_fail++;
            $display("FAIL captured_data: %0d cycles differed from 55/rs1, want 0", bad_d);
        end
        n_checks++;
        if (acks1 != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdrawn_req: ack1_cycles=%0d busy=%b, want 0 0", acks1, busy);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n, bad;
        req_data[15:8] = 8'h42; req_rs[1] = 1'b1; req[1] = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            if (ack !== 2'b00) req = 2'b00;
        end while (lcd_e !== 1'b1 && n < 20);
        n_checks++;
        if (lcd_e !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_timeout: lcd_e=%b after %0d cycles, want 1", lcd_e, n);
        end
        #2;
        rst_n = 1'b0; init_done = 1'b0;
        #1;
        n_checks++;
        if (lcd_e !== 1'b0 || busy !== 1'b1 || ack !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: e=%b busy=%b ack=%b, want 0 1 00", lcd_e, busy, ack);
        end
        tick();
        rst_n = 1'b1;
        req_data[7:0] = 8'h43; req_rs[0] = 1'b1; req[0] = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack !== 2'b00 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_passthrough: %0d cycles with ack or not busy, want 0", bad);
        end
        init_done = 1'b1;
        tick();
        n_checks++;
        if (ack !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_init_edge: ack=%b, want 00", ack);
        end
        sb.push_back('{id: 0, data: 8'h43, rs: 1'b1});
        tick();
        begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (ack !== NR'(1 << e.id) || grant_id !== 2'(e.id) || lcd_data !== e.data) begin
                n_fail++;
                $display("FAIL post_reset_first_grant: ack=%b grant_id=%0d data=%h, want id %0d %h", ack, grant_id, lcd_data, e.id, e.data);
            end
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_init_same_edge();
        test_single_write(0, 8'h41, 1'b1);
        test_single_write(1, 8'h01, 1'b0);
        test_contention();
        test_withdraw_stable();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_write_sched.md
Name: lcd_write_sched

Overview:
- Post-initialisation write scheduler for the HD44780 character LCD.
- Shares the 8-bit LCD bus between NUM_REQ requesters, for example a CPU status printer and a cursor/command unit.
- Sequences each accepted write through the setup, E-pulse, hold and busy-wait phases.
- Until the init sequencer reports done, it passes the init sequencer's bus signals straight through and grants nothing.

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..4.
- SETUP_CYC, 5: cycles the data/RS lines are stable before E rises; also the hold cycles after E falls.
- PULSE_CYC, 50: cycles E is held high.
- STD_WAIT, 2000: post-pulse wait for ordinary commands and characters.
- LONG_WAIT, 90000: post-pulse wait for clear/home commands.
- CNT_W, 32: delay counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  done flag from the init sequencer
- init_data  in  8  init sequencer LCD data
- init_rs  in  1  init sequencer RS
- init_rw  in  1  init sequencer RW
- init_e  in  1  init sequencer E
- req  in  NUM_REQ  per-requester write request, level
- req_data  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i]
- req_rs  in  NUM_REQ  RS for requester i (0 = command, 1 = character)
- ack  out  NUM_REQ  one-cycle accept pulse, one-hot
- grant_id  out  2  index of the requester being serviced, valid while busy after init
- busy  out  1  high while not ready to accept a request
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW
- lcd_e  out  1  LCD enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- On rst_n low:
  - state = IDLE, init_seen = 0, counter = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - ack = 0, grant_id = 0, busy = 1.
  - lcd_* follow init_* (all 0 while the init sequencer is in reset).
- init_seen:
  - Sticky flag, set on the first clk edge with init_done = 1.
  - Cleared only by rst_n.
- While init_seen = 0:
  - lcd_data/rs/rw/e = init_* combinationally.
  - FSM held in IDLE, no ack, busy = 1.
- After init_seen = 1:
  - lcd_* are driven from registered scheduler state.
  - lcd_rw is always 0.
- FSM states IDLE, SETUP, PULSE, HOLD, WAIT:
  - IDLE: lcd_e = 0, lcd_data = 0, lcd_rs = 0, busy = 0.
    - If any req is set, pick the first set bit searching upward (with wrap) from pointer+1.
    - Latch that requester's data and rs, set the pointer and grant_id to it, go to SETUP, counter = SETUP_CYC-1.
  - SETUP: ack[grant] = 1 in the first SETUP cycle only. Data/RS driven, E = 0. Go to PULSE when the counter reaches 0; counter = PULSE_CYC-1.
  - PULSE: E = 1. Go to HOLD when the counter reaches 0; counter = SETUP_CYC-1.
  - HOLD: E = 0, data/RS held. Go to WAIT when the counter reaches 0; counter = wait-1.
    - wait = LONG_WAIT if rs = 0 and data is 0x01, 0x02 or 0x03 (clear/home); otherwise STD_WAIT.
  - WAIT: E = 0, data/RS held. Go to IDLE when the counter reaches 0.
- Latency:
  - A request sampled in IDLE at edge t gives ack at cycle t+1.
  - E is high for exactly PULSE_CYC cycles, starting SETUP_CYC cycles after ack.
  - busy falls 2*SETUP_CYC + PULSE_CYC + wait cycles after ack.
  - There is at least one IDLE cycle between transactions.
- Requester rules:
  - Hold req, data and rs stable until ack. Dropping req before ack withdraws the request with no side effect.
  - Data is captured at grant; later changes are ignored.
- Simultaneous requests: round-robin. The last-served requester has lowest priority next time.
- If init_done and req arrive on the same edge, only init_seen is set; arbitration starts on the next edge.
- A mid-transaction rst_n assertion drops lcd_e and ack immediately and returns to pass-through. The interrupted requester gets no ack beyond any already issued.
- Counter arithmetic: CNT_W unsigned. Parameters must be at least 1; a value of 1 means a single-cycle phase.

Decomposition:
- Package lcd_pkg:
  - HD44780 command constants (FUNCTION_SET 0x38, DISPLAY_ON 0x0C, CLEAR 0x01, HOME 0x02, ENTRY_MODE 0x06).
  - Default delay constants.
  - FSM state encoding (3-bit).
- One sub-module: lcd_rr_arbiter.
  - Combinational round-robin pick from req and the pointer.
  - Outputs a one-hot grant and an index.
  - Instantiated once.

Test Plan (bench params SETUP_CYC=2, PULSE_CYC=4, STD_WAIT=10, LONG_WAIT=40):
- Pass-through: hold init_done = 0, drive init_data = 0x38, init_e = 1.
  - Required: lcd_data = 0x38, lcd_e = 1 in the same cycle; busy = 1; req[0] never acked.
- Single character: init_done = 1, then req[0] with data 0x41, rs = 1 sampled at edge t.
  - Required: ack[0] at t+1; lcd_e high t+3..t+6; lcd_data = 0x41, lcd_rs = 1 from t+1..t+18; busy low at t+19.
- Clear command: req[1] with data 0x01, rs = 0.
  - Required: same timing through E; WAIT lasts 40 cycles; busy low at t+49.
- Contention: req[0] and req[1] both set and held continuously.
  - Required: acks alternate 0, 1, 0, 1; grant_id matches each ack; each transaction completes before the next ack.
- Withdrawal and stability:
  - req[1] pulsed for one cycle while busy: never acked.
  - req_data changed after ack: lcd_data still shows the captured byte.
- Reset mid-PULSE: assert rst_n low while lcd_e = 1.
  - Required: lcd_e = 0 asynchronously; busy = 1; after release, no ack until init_done is seen again.
